// File: rtl/clock_controller_if.sv
// Key pulses into, and time/display state out of, the clock controller.
interface clock_controller_if;
    logic       keySet;
    logic       keyInc;
    logic       keyMode;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       minOrSec;
    logic [3:0] blinkMask;
    logic       secTick;
    logic       setting;

    modport master (output keySet, keyInc, keyMode,
                    input  hour, min, sec, minOrSec, blinkMask, secTick, setting);
    modport slave  (input  keySet, keyInc, keyMode,
                    output hour, min, sec, minOrSec, blinkMask, secTick, setting);
endinterface

// File: rtl/clock_controller.sv
// Timekeeping, set-time FSM and blink mask generation for the 7-segment clock.
module clock_controller #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic               clk,
    input  logic               rstN,
    clock_controller_if.slave  bus
);
    localparam logic [25:0] TICK_LAST  = 26'(TICK_DIV - 1);
    localparam logic [25:0] BLINK_LAST = 26'(BLINK_DIV - 1);

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;

    state_t      state_q, state_d;
    logic [25:0] presc_q, presc_d;
    logic [25:0] blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic        min_or_sec_q, min_or_sec_d;
    logic        sec_tick_q, sec_tick_d;
    logic        setting_q, setting_d;
    logic [3:0]  blink_mask_q, blink_mask_d;

    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        hour_d        = hour_q;
        min_d         = min_q;
        sec_d         = sec_q;
        min_or_sec_d  = min_or_sec_q;
        sec_tick_d    = 1'b0;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        setting_d     = 1'b0;
        blink_mask_d  = 4'b0000;

        // keySet always wins; the other keys are only looked at when it is low
        case (state_q)
            RUN: begin
                if (bus.keySet) begin
                    state_d      = SET_HOUR;
                    presc_d      = '0;
                    min_or_sec_d = 1'b0;
                end else begin
                    if (bus.keyMode)
                        min_or_sec_d = ~min_or_sec_q;
                    if (presc_q == TICK_LAST) begin
                        presc_d    = '0;
                        sec_tick_d = 1'b1;
                        if (sec_q == 6'd59) begin
                            sec_d = '0;
                            if (min_q == 6'd59) begin
                                min_d  = '0;
                                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                            end else begin
                                min_d = min_q + 6'd1;
                            end
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end else begin
                        presc_d = presc_q + 26'd1;
                    end
                end
            end
            SET_HOUR: begin
                presc_d      = '0;
                min_or_sec_d = 1'b0;
                if (bus.keySet)
                    state_d = SET_MIN;
                else if (bus.keyInc)
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end
            SET_MIN: begin
                presc_d      = '0;
                min_or_sec_d = 1'b0;
                if (bus.keySet) begin
                    state_d = RUN;
                    sec_d   = '0;
                end else if (bus.keyInc) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: state_d = RUN;
        endcase

        // Restarting the blink counter with the phase makes each new state
        // begin with a full unblanked half-period.
        if (state_d != state_q) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 26'd1;
        end

        setting_d = (state_d != RUN);
        if (blink_phase_d) begin
            if (state_d == SET_HOUR)
                blink_mask_d = 4'b1100;
            else if (state_d == SET_MIN)
                blink_mask_d = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q       <= RUN;
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            hour_q        <= '0;
            min_q         <= '0;
            sec_q         <= '0;
            min_or_sec_q  <= 1'b0;
            sec_tick_q    <= 1'b0;
            setting_q     <= 1'b0;
            blink_mask_q  <= '0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            hour_q        <= hour_d;
            min_q         <= min_d;
            sec_q         <= sec_d;
            min_or_sec_q  <= min_or_sec_d;
            sec_tick_q    <= sec_tick_d;
            setting_q     <= setting_d;
            blink_mask_q  <= blink_mask_d;
        end
    end

    assign bus.hour      = hour_q;
    assign bus.min       = min_q;
    assign bus.sec       = sec_q;
    assign bus.minOrSec  = min_or_sec_q;
    assign bus.blinkMask = blink_mask_q;
    assign bus.secTick   = sec_tick_q;
    assign bus.setting   = setting_q;
endmodule

// File: tb/tb_clock_controller.sv
// Directed bench for clock_controller with TICK_DIV=4 and BLINK_DIV=8.
module tb_clock_controller;
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    clock_controller_if bus();
    clock_controller #(.TICK_DIV(4), .BLINK_DIV(8)) dut (.clk(clk), .rstN(rstN), .bus(bus));

    typedef struct {
        logic       s, i, m;
        logic [4:0] hour;
        logic [5:0] min, sec;
        logic       mos;
        logic [3:0] mask;
        logic       tick, setting;
    } vec_t;

    vec_t vecs[20];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(logic s, logic i, logic m, logic [4:0] h, logic [5:0] mn,
                               logic [5:0] sc, logic mos, logic [3:0] mask, logic tick, logic set);
        vec_t r;
        r.s = s; r.i = i; r.m = m; r.hour = h; r.min = mn; r.sec = sc;
        r.mos = mos; r.mask = mask; r.tick = tick; r.setting = set;
        return r;
    endfunction

    function automatic logic [23:0] want(logic [4:0] h, logic [5:0] mn, logic [5:0] sc,
                                         logic mos, logic [3:0] mask, logic tick, logic set);
        return {h, mn, sc, mos, mask, tick, set};
    endfunction

    function automatic logic [23:0] outs();
        return {bus.hour, bus.min, bus.sec, bus.minOrSec, bus.blinkMask, bus.secTick, bus.setting};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic i, input logic m);
        bus.keySet = s; bus.keyInc = i; bus.keyMode = m;
        @(posedge clk);
        #1;
        bus.keySet = 1'b0; bus.keyInc = 1'b0; bus.keyMode = 1'b0;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.keySet = 1'b0; bus.keyInc = 1'b0; bus.keyMode = 1'b0;
        rstN = 1'b0;

        //           s  i  m  hour min sec mos mask     tick set
        vecs[0]  = v(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        vecs[1]  = v(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        vecs[2]  = v(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        vecs[3]  = v(0, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 0);
        vecs[4]  = v(0, 0, 1, 0, 0, 1, 1, 4'b0000, 0, 0);
        vecs[5]  = v(0, 1, 1, 0, 0, 1, 0, 4'b0000, 0, 0);
        vecs[6]  = v(0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
        vecs[7]  = v(0, 0, 0, 0, 0, 2, 0, 4'b0000, 1, 0);
        vecs[8]  = v(0, 0, 1, 0, 0, 2, 1, 4'b0000, 0, 0);
        vecs[9]  = v(1, 0, 1, 0, 0, 2, 0, 4'b0000, 0, 1);
        vecs[10] = v(0, 1, 0, 1, 0, 2, 0, 4'b0000, 0, 1);
        vecs[11] = v(0, 0, 1, 1, 0, 2, 0, 4'b0000, 0, 1);
        vecs[12] = v(1, 1, 0, 1, 0, 2, 0, 4'b0000, 0, 1);
        vecs[13] = v(0, 1, 0, 1, 1, 2, 0, 4'b0000, 0, 1);
        vecs[14] = v(0, 0, 1, 1, 1, 2, 0, 4'b0000, 0, 1);
        vecs[15] = v(1, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
        vecs[16] = v(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
        vecs[17] = v(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
        vecs[18] = v(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
        vecs[19] = v(0, 0, 0, 1, 1, 1, 0, 4'b0000, 1, 0);

        // Reset state, then the vector table from the first released edge
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(outs()), 32'(want(0, 0, 0, 0, 4'b0000, 0, 0)));
        rstN = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step(vecs[n].s, vecs[n].i, vecs[n].m);
            chk($sformatf("vec%0d", n), 32'(outs()),
                32'(want(vecs[n].hour, vecs[n].min, vecs[n].sec, vecs[n].mos,
                         vecs[n].mask, vecs[n].tick, vecs[n].setting)));
        end

        // Set sequence with blink checks
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0);
            chk($sformatf("run_tick%0d", k), 32'(outs()),
                32'(want(0, 0, 6'(k / 4), 0, 4'b0000, (k % 4) == 0, 0)));
        end
        step(1, 0, 0);
        chk("enter_set_hour", 32'(outs()), 32'(want(0, 0, 2, 0, 4'b0000, 0, 1)));
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0);
            chk($sformatf("blink_hour%0d", k), 32'(bus.blinkMask),
                ((k / 8) % 2) ? 32'hC : 32'h0);
        end
        inc_n(25);
        chk("hour_25_inc", 32'({bus.hour, bus.min, bus.sec}), 32'({5'd1, 6'd0, 6'd2}));
        step(1, 0, 0);
        chk("enter_set_min", 32'(outs()), 32'(want(1, 0, 2, 0, 4'b0000, 0, 1)));
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0);
            chk($sformatf("blink_min%0d", k), 32'(bus.blinkMask),
                ((k / 8) % 2) ? 32'h3 : 32'h0);
        end
        step(0, 0, 1);
        chk("mode_in_set_min", 32'(bus.minOrSec), 32'h0);
        inc_n(61);
        chk("min_61_inc", 32'({bus.hour, bus.min}), 32'({5'd1, 6'd1}));
        step(1, 0, 0);
        chk("exit_to_run", 32'(outs()), 32'(want(1, 1, 0, 0, 4'b0000, 0, 0)));
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0);
            chk($sformatf("first_tick%0d", k), 32'({bus.secTick, bus.sec}),
                32'({k == 4, (k == 4) ? 6'd1 : 6'd0}));
        end

        // Rollover 23:59:58 -> 23:59:59 -> 00:00:00
        do_reset();
        step(1, 0, 0);
        inc_n(23);
        chk("hour_23", 32'(bus.hour), 32'd23);
        step(0, 1, 0);
        chk("hour_wrap", 32'(bus.hour), 32'd0);
        inc_n(23);
        step(1, 0, 0);
        inc_n(59);
        chk("min_59", 32'({bus.hour, bus.min}), 32'({5'd23, 6'd59}));
        step(1, 0, 0);
        for (int k = 0; k < 58 * 4; k++) step(0, 0, 0);
        chk("preload", 32'(outs()), 32'(want(23, 59, 58, 0, 4'b0000, 1, 0)));
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0);
            if (k < 4)
                chk($sformatf("roll%0d", k), 32'(outs()), 32'(want(23, 59, 58, 0, 4'b0000, 0, 0)));
            else if (k < 8)
                chk($sformatf("roll%0d", k), 32'(outs()), 32'(want(23, 59, 59, 0, 4'b0000, k == 4, 0)));
            else
                chk($sformatf("roll%0d", k), 32'(outs()), 32'(want(0, 0, 0, 0, 4'b0000, 1, 0)));
        end

        // Reset mid-operation in SET_MIN at 12:34
        do_reset();
        step(1, 0, 0);
        inc_n(12);
        step(1, 0, 0);
        inc_n(34);
        chk("at_12_34", 32'({bus.hour, bus.min, bus.setting}), 32'({5'd12, 6'd34, 1'b1}));
        rstN = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset", 32'(outs()), 32'(want(0, 0, 0, 0, 4'b0000, 0, 0)));
        rstN = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0);
            chk($sformatf("post_reset%0d", k), 32'(outs()),
                32'(want(0, 0, (k == 4) ? 6'd1 : 6'd0, 0, 4'b0000, k == 4, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
